// File: rtl/attr_host_ctrl.sv
// attr_host_ctrl: host-side access to the VGA attribute controller.
// The 3C0h index/data flip-flop selects either a palette entry (00h-0Fh)
// or one of the attribute registers 10h-14h. It drives the write/read port
// of the 16x6 palette bank and sequences palette read-back to the host
// through a three-state read FSM.
// Optional build macro: ATTR_PAS_LOCK_EN. When defined, palette writes are
// suppressed and palette reads return 00h while pas=1.
//
// Host handshake: h_wr_3c0, h_rd_3c1 and h_rd_3da are single-cycle strobes
// with no back-pressure. A read request is answered by exactly one
// h_rd_ack pulse, and h_rdata is valid in that cycle. A read request that
// arrives while a palette write pulse is on the bank is held for one cycle.
// A read request that arrives while a read is in flight is dropped, and so
// is a 3C0h write that arrives while the palette read is waiting on the bank.
module attr_host_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic       h_hclk,
  input  logic       h_reset_n,
  input  logic       h_wr_3c0,
  input  logic       h_rd_3c1,
  input  logic       h_rd_3da,
  input  logic [7:0] h_wdata,
  output logic [7:0] h_rdata,
  output logic       h_rd_ack,
  output logic       pal_we,
  output logic [3:0] pal_addr,
  output logic [5:0] pal_din,
  input  logic [5:0] pal_dout,
  output logic [4:0] attr_index,
  output logic       pas,
  output logic       ff_state,
  output logic [7:0] mode_ctl,
  output logic [7:0] overscan,
  output logic [3:0] plane_en,
  output logic [3:0] hpan,
  output logic [3:0] color_sel,
  output logic [1:0] o_rd_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } rd_state_t;

  localparam logic [1:0] LAT = RD_LAT[1:0];

  rd_state_t r_state;
  logic [1:0] r_cnt;
  logic       r_rd_pend;
  logic [7:0] r_rdata;
  logic       r_rd_ack;

  logic       r_ff;
  logic [4:0] r_attr_index;
  logic       r_pas;
  logic       r_pal_we;
  logic [5:0] r_pal_din;
  logic [7:0] r_mode_ctl;
  logic [7:0] r_overscan;
  logic [3:0] r_plane_en;
  logic [3:0] r_hpan;
  logic [3:0] r_color_sel;

  logic       w_wr;
  logic       w_wr_idx;
  logic       w_wr_data;
  logic       w_pal_sel;
  logic       w_lock;
  logic       w_pal_wr;
  logic       w_rd_req;
  logic       w_rd_accept;
  logic [7:0] w_reg_rdata;
  logic [7:0] w_pal_rdata;

  // A 3C0h write is discarded when an input-status read coincides with it
  // or while a palette read waits on the bank (pal_addr must stay stable).
  assign w_wr      = h_wr_3c0 & ~h_rd_3da & (r_state != S_WAIT);
  assign w_wr_idx  = w_wr & ~r_ff;
  assign w_wr_data = w_wr & r_ff;
  assign w_pal_sel = ~r_attr_index[4];

`ifdef ATTR_PAS_LOCK_EN
  assign w_lock = r_pas;
`else
  assign w_lock = 1'b0;
`endif

  assign w_pal_wr    = w_wr_data & w_pal_sel & ~w_lock;
  assign w_rd_req    = h_rd_3c1 | r_rd_pend;
  assign w_rd_accept = (r_state == S_IDLE) & w_rd_req & ~r_pal_we;
  assign w_pal_rdata = w_lock ? 8'h00 : {2'b00, pal_dout};

  // Register read-back mux; unimplemented indices read as zero.
  always_comb begin
    w_reg_rdata = 8'h00;
    case (r_attr_index)
      5'h10:   w_reg_rdata = r_mode_ctl;
      5'h11:   w_reg_rdata = r_overscan;
      5'h12:   w_reg_rdata = {4'h0, r_plane_en};
      5'h13:   w_reg_rdata = {4'h0, r_hpan};
      5'h14:   w_reg_rdata = {4'h0, r_color_sel};
      default: w_reg_rdata = 8'h00;
    endcase
  end

  // Flip-flop protocol, index/pas capture, palette write pulse and registers.
  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      r_ff         <= 1'b0;
      r_attr_index <= 5'h00;
      r_pas        <= 1'b0;
      r_pal_we     <= 1'b0;
      r_pal_din    <= 6'h00;
      r_mode_ctl   <= 8'h00;
      r_overscan   <= 8'h00;
      r_plane_en   <= 4'h0;
      r_hpan       <= 4'h0;
      r_color_sel  <= 4'h0;
    end else begin
      r_pal_we <= w_pal_wr;
      if (h_rd_3da) begin
        r_ff <= 1'b0;
      end else if (w_wr_idx) begin
        r_attr_index <= h_wdata[4:0];
        r_pas        <= h_wdata[5];
        r_ff         <= 1'b1;
      end else if (w_wr_data) begin
        r_ff <= 1'b0;
        if (w_pal_wr) begin
          r_pal_din <= h_wdata[5:0];
        end
        case (r_attr_index)
          5'h10:   r_mode_ctl  <= h_wdata;
          5'h11:   r_overscan  <= h_wdata;
          5'h12:   r_plane_en  <= h_wdata[3:0];
          5'h13:   r_hpan      <= h_wdata[3:0];
          5'h14:   r_color_sel <= h_wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  // Read FSM: registers answer next cycle, palette waits RD_LAT cycles.
  always_ff @(posedge h_hclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_rd_pend <= 1'b0;
      r_rdata   <= 8'h00;
      r_rd_ack  <= 1'b0;
    end else begin
      r_rd_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Hold a request that collides with a palette write pulse so the
          // bank sees the new data before the read is issued.
          r_rd_pend <= w_rd_req & r_pal_we;
          if (w_rd_accept) begin
            if (w_pal_sel) begin
              r_state <= S_WAIT;
              r_cnt   <= LAT;
            end else begin
              r_state  <= S_DONE;
              r_rdata  <= w_reg_rdata;
              r_rd_ack <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_rd_pend <= 1'b0;
          r_cnt     <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_rdata  <= w_pal_rdata;
            r_rd_ack <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_rd_pend <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_rd_pend <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign h_rdata    = r_rdata;
  assign h_rd_ack   = r_rd_ack;
  assign pal_we     = r_pal_we;
  assign pal_addr   = r_attr_index[3:0];
  assign pal_din    = r_pal_din;
  assign attr_index = r_attr_index;
  assign pas        = r_pas;
  assign ff_state   = r_ff;
  assign mode_ctl   = r_mode_ctl;
  assign overscan   = r_overscan;
  assign plane_en   = r_plane_en;
  assign hpan       = r_hpan;
  assign color_sel  = r_color_sel;
  assign o_rd_state = r_state;

endmodule

// File: tb/tb_attr_host_ctrl.sv
// tb_attr_host_ctrl: directed bench for attr_host_ctrl with a 16x6 palette
// bank model (one-cycle read latency). Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_attr_host_ctrl;

  localparam int RD_LAT = 1;

  logic       clk;
  logic       rst_n;
  logic       h_wr_3c0;
  logic       h_rd_3c1;
  logic       h_rd_3da;
  logic [7:0] h_wdata;
  logic [7:0] h_rdata;
  logic       h_rd_ack;
  logic       pal_we;
  logic [3:0] pal_addr;
  logic [5:0] pal_din;
  logic [5:0] pal_dout;
  logic [4:0] attr_index;
  logic       pas;
  logic       ff_state;
  logic [7:0] mode_ctl;
  logic [7:0] overscan;
  logic [3:0] plane_en;
  logic [3:0] hpan;
  logic [3:0] color_sel;
  logic [1:0] rd_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [5:0] mem [16];

  attr_host_ctrl #(.RD_LAT(RD_LAT)) dut (
    .h_hclk(clk), .h_reset_n(rst_n),
    .h_wr_3c0(h_wr_3c0), .h_rd_3c1(h_rd_3c1), .h_rd_3da(h_rd_3da),
    .h_wdata(h_wdata), .h_rdata(h_rdata), .h_rd_ack(h_rd_ack),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_din(pal_din),
    .pal_dout(pal_dout), .attr_index(attr_index), .pas(pas),
    .ff_state(ff_state), .mode_ctl(mode_ctl), .overscan(overscan),
    .plane_en(plane_en), .hpan(hpan), .color_sel(color_sel),
    .o_rd_state(rd_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // palette bank model: write on pal_we, registered read (latency 1)
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 6'h00;
    pal_dout = 6'h00;
  end
  always @(posedge clk) begin
    if (pal_we) mem[pal_addr] <= pal_din;
    pal_dout <= mem[pal_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks (entered and left on a falling edge)
  task automatic wr3c0(input logic [7:0] d);
    h_wdata  = d;
    h_wr_3c0 = 1'b1;
    @(negedge clk);
    h_wr_3c0 = 1'b0;
  endtask

  task automatic pulse_3da();
    h_rd_3da = 1'b1;
    @(negedge clk);
    h_rd_3da = 1'b0;
  endtask

  // Poll for ack starting at the current falling edge (k=1), bounded.
  task automatic wait_ack(output int k);
    k = 1;
    while (!h_rd_ack && k <= 10) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Issue a 3C1h read; k=1 is the cycle after the strobe cycle.
  task automatic do_read(input string tag, input int exp_k,
                         input logic [7:0] exp_d);
    int k;
    h_rd_3c1 = 1'b1;
    @(negedge clk);
    h_rd_3c1 = 1'b0;
    wait_ack(k);
    check({tag, "_lat"}, k, exp_k);
    check({tag, "_data"}, h_rdata, exp_d);
    @(negedge clk);
    check({tag, "_ack_once"}, h_rd_ack, 0);
  endtask

  initial begin
    int k;
    logic saw_ack;
    rst_n = 1'b0; h_wr_3c0 = 1'b0; h_rd_3c1 = 1'b0; h_rd_3da = 1'b0;
    h_wdata = 8'h00;
    @(negedge clk); @(negedge clk);
    check("rst_outs", {h_rdata, h_rd_ack, pal_we, pal_addr, pal_din,
                       attr_index, pas, ff_state}, 0);
    check("rst_regs", {mode_ctl, overscan, plane_en, hpan, color_sel}, 0);
    check("rst_fsm", rd_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // palette write
    wr3c0(8'h05);
    check("idx_ff", ff_state, 1);
    check("idx_val", attr_index, 5'h05);
    check("idx_addr", pal_addr, 4'h5);
    check("idx_no_we", pal_we, 0);
    wr3c0(8'h2A);
    check("pw_we", pal_we, 1);
    check("pw_din", pal_din, 6'h2A);
    check("pw_addr", pal_addr, 4'h5);
    check("pw_ff", ff_state, 0);
    @(negedge clk);
    check("pw_we_once", pal_we, 0);

    // palette read, RD_LAT=1: ack two cycles after the strobe cycle
    wr3c0(8'h05);
    do_read("pal_rd", 2, 8'h2A);
    check("rd_keeps_ff", ff_state, 1);
    pulse_3da();
    check("3da_clr", ff_state, 0);

    // register path
    wr3c0(8'h13); wr3c0(8'hF7);
    check("hpan", hpan, 4'h7);
    do_read("reg13", 1, 8'h07);
    check("reg_rd_ff", ff_state, 0);
    wr3c0(8'h12); wr3c0(8'hFF);
    check("plane_en", plane_en, 4'hF);
    wr3c0(8'h14); wr3c0(8'hA9);
    check("color_sel", color_sel, 4'h9);
    wr3c0(8'h1C);
    do_read("reg1c", 1, 8'h00);
    pulse_3da();

    // flip-flop handling
    wr3c0(8'h10);
    pulse_3da();
    check("ff_after_3da", ff_state, 0);
    wr3c0(8'h11); wr3c0(8'h3F);
    check("overscan", overscan, 8'h3F);
    check("mode_ctl_keep", mode_ctl, 8'h00);
    h_wdata = 8'h12; h_wr_3c0 = 1'b1; h_rd_3da = 1'b1;
    @(negedge clk);
    h_wr_3c0 = 1'b0; h_rd_3da = 1'b0;
    check("coll_idx_ff", ff_state, 0);
    check("coll_idx_keep", attr_index, 5'h11);
    wr3c0(8'h10);
    h_wdata = 8'hAA; h_wr_3c0 = 1'b1; h_rd_3da = 1'b1;
    @(negedge clk);
    h_wr_3c0 = 1'b0; h_rd_3da = 1'b0;
    check("coll_data_ff", ff_state, 0);
    check("coll_data_lost", mode_ctl, 8'h00);

    // read colliding with pal_we: deferred one cycle, returns new data
    wr3c0(8'h07);
    h_wdata = 8'h15; h_wr_3c0 = 1'b1;
    @(negedge clk);
    h_wr_3c0 = 1'b0; h_rd_3c1 = 1'b1;
    check("haz_we", pal_we, 1);
    @(negedge clk);
    h_rd_3c1 = 1'b0;
    wait_ack(k);
    check("haz_lat", k, 3);
    check("haz_data", h_rdata, 8'h15);
    @(negedge clk);

    // 3C0h write during WAIT is dropped
    h_rd_3c1 = 1'b1;
    @(negedge clk);
    h_rd_3c1 = 1'b0;
    h_wdata = 8'h03; h_wr_3c0 = 1'b1;
    @(negedge clk);
    h_wr_3c0 = 1'b0;
    check("wwait_ack", h_rd_ack, 1);
    check("wwait_data", h_rdata, 8'h15);
    check("wwait_idx", attr_index, 5'h07);
    check("wwait_ff", ff_state, 0);
    @(negedge clk);

    // reset asserted in WAIT
    h_rd_3c1 = 1'b1;
    @(negedge clk);
    h_rd_3c1 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstw_outs", {h_rdata, h_rd_ack, attr_index, ff_state, pal_din}, 0);
    check("rstw_regs", {overscan, plane_en, hpan, color_sel, rd_state}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (h_rd_ack) saw_ack = 1'b1;
    end
    check("rstw_no_ack", saw_ack, 0);

    // pas handling on palette access
    wr3c0(8'h25);
    check("pas_set", pas, 1);
    wr3c0(8'h11);
    check("pas_ff", ff_state, 0);
`ifdef ATTR_PAS_LOCK_EN
    check("pas_we", pal_we, 0);
`else
    check("pas_we", pal_we, 1);
`endif
    wr3c0(8'h25);
`ifdef ATTR_PAS_LOCK_EN
    do_read("pas_rd", 2, 8'h00);
`else
    do_read("pas_rd", 2, 8'h11);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/attr_host_ctrl.md
Name: attr_host_ctrl

Overview:
Host-side writer and reader for the VGA attribute controller. It decodes the 3C0h index/data flip-flop protocol and drives the write/read port of the 16x6 attribute palette bank: pal_we, pal_addr and pal_din go out to the bank, and the bank's host read data returns on pal_dout. It also holds attribute registers 10h-14h and sequences palette read-back to the host through a small read state machine.

Parameters:
RD_LAT, 1, palette bank host-read latency in h_hclk cycles from a stable pal_addr to valid pal_dout (legal 1-3)

Ports:
h_hclk  in  1  host clock; the only clock in the block
h_reset_n  in  1  asynchronous active-low reset
h_wr_3c0  in  1  one-cycle host write strobe to port 3C0h
h_rd_3c1  in  1  one-cycle host read request to port 3C1h
h_rd_3da  in  1  one-cycle input-status read; clears the flip-flop
h_wdata  in  8  host write data
h_rdata  out  8  host read data
h_rd_ack  out  1  one-cycle pulse; h_rdata is valid in this cycle
pal_we  out  1  palette bank write enable
pal_addr  out  4  palette bank address
pal_din  out  6  palette bank write data
pal_dout  in  6  palette bank host read data
attr_index  out  5  current attribute index
pas  out  1  palette address source bit
ff_state  out  1  flip-flop state: 0 = index phase, 1 = data phase
mode_ctl  out  8  register 10h
overscan  out  8  register 11h
plane_en  out  4  register 12h[3:0]
hpan  out  4  register 13h[3:0]
color_sel  out  4  register 14h[3:0]

Behaviour:
- Reset: every output and register is 0. The read FSM goes to IDLE. This applies at any time, including mid-read; an aborted read produces no ack.
- pal_addr = attr_index[3:0] at all times.
- h_wr_3c0 with ff=0: attr_index <= h_wdata[4:0]; pas <= h_wdata[5]; ff <= 1.
- h_wr_3c0 with ff=1, by index:
  - 00h-0Fh: pal_we is high for exactly one cycle, the cycle after the strobe; pal_din <= h_wdata[5:0] and holds until the next palette write.
  - 10h-14h: load the named register. 12h, 13h and 14h keep only bits [3:0].
  - 15h-1Fh: ignored.
  - In every case ff <= 0.
- h_rd_3da: ff <= 0. It has priority over a simultaneous h_wr_3c0, which is discarded entirely.
- Read FSM states: IDLE, WAIT, DONE.
  - IDLE: h_rd_3c1 is accepted in cycle T only if pal_we=0. If it arrives while pal_we=1, it is held and accepted in the next cycle.
    - Index 00h-0Fh: go to WAIT and load a counter with RD_LAT.
    - Index 10h-1Fh: go to DONE. h_rdata = register value, zero-extended; 15h-1Fh read as 00h.
  - WAIT: decrement the counter. At 0, capture h_rdata = {2'b00, pal_dout} and go to DONE.
  - DONE: h_rd_ack=1 for one cycle, then back to IDLE.
  - Palette read: h_rd_ack is high in cycle T+1+RD_LAT. Register read: h_rd_ack is high in cycle T+1.
  - h_rdata holds its value until the next ack.
- h_rd_3c1 while the FSM is not IDLE is dropped.
- h_wr_3c0 while the FSM is in WAIT is dropped, so pal_addr stays stable.
- Reads never toggle ff.
- A read of a palette entry written earlier returns the new value, because acceptance is deferred while pal_we is high.

Optional Feature:
ATTR_PAS_LOCK_EN
- Defined: while pas=1, palette data writes (index 00h-0Fh) are suppressed: pal_we stays 0, but ff still toggles. Palette reads while pas=1 return 00h with unchanged timing.
- Undefined: pas has no effect on host palette access.

Test Plan:
- Reset, then write 3C0=05h, 3C0=2Ah -> pal_we pulses once with pal_addr=5 and pal_din=2Ah; ff goes 1 then 0.
- Palette read, RD_LAT=1: write entry 5 = 2Ah; 3C0=05h; h_rd_3c1 in cycle T -> h_rd_ack in cycle T+2 with h_rdata=2Ah.
- Register path: 3C0=13h, 3C0=F7h -> hpan=7h. h_rd_3c1 -> ack in cycle T+1 with h_rdata=07h. Index 1Ch reads 00h.
- Flip-flop: 3C0=10h, then h_rd_3da, then 3C0=11h, 3C0=3Fh -> overscan=3Fh and mode_ctl unchanged. h_rd_3da and h_wr_3c0 in the same cycle -> write lost, ff=0.
- Hazards: h_rd_3c1 in the same cycle as pal_we -> accepted one cycle later and returns the new data. h_wr_3c0 during WAIT -> dropped, attr_index unchanged. Reset asserted in WAIT -> no ack, all outputs 0.
- With ATTR_PAS_LOCK_EN defined: 3C0=25h, 3C0=11h -> pal_we stays 0 and a read returns 00h. Without the macro -> entry 5 = 11h.
